// File: rtl/bar_viz_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bar_viz_pkg
//  Brief   : Shared constants and types for the bar-height visualiser blocks.
//  Revision: 1.0
// ============================================================================
package bar_viz_pkg;

    localparam int NUM_BARS   = 20;
    localparam int HEIGHT_W   = 6;
    localparam int MAX_HEIGHT = (1 << HEIGHT_W) - 1;

    typedef logic [HEIGHT_W-1:0] height_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        NOTIFY  = 2'd2,
        GUARD   = 2'd3
    } writer_state_e;

endpackage
`default_nettype wire

// File: rtl/bar_height_writer_if.sv
`default_nettype none
// ============================================================================
//  Module  : bar_height_writer_if
//  Brief   : FIFO read side, bar-height RAM write port and data_back flag.
//  Revision: 1.0
// ============================================================================
interface bar_height_writer_if #(
    parameter int HEIGHT_W = bar_viz_pkg::HEIGHT_W,
    parameter int ADDR_W   = 6
);
    logic [31:0]         fifo_q;
    logic                fifo_rdempty;
    logic                fifo_rdreq;
    logic [HEIGHT_W-1:0] ram_data;
    logic [ADDR_W-1:0]   ram_wraddress;
    logic                ram_wren;
    logic                data_back;

    modport master (
        input  fifo_q, fifo_rdempty,
        output fifo_rdreq, ram_data, ram_wraddress, ram_wren, data_back
    );

    modport slave (
        output fifo_q, fifo_rdempty,
        input  fifo_rdreq, ram_data, ram_wraddress, ram_wren, data_back
    );
endinterface
`default_nettype wire

// File: rtl/bar_height_writer_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module  : peak_detector
//  Brief   : Running peak of |sample| over a window, shifted and saturated.
//  Revision: 1.0
// ============================================================================
module peak_detector #(
    parameter int SHIFT    = 9,
    parameter int HEIGHT_W = 6
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                valid,
    input  wire logic                clear,
    input  wire logic [15:0]         sample,
    output logic      [HEIGHT_W-1:0] height
);
    localparam logic [15:0] SAT = 16'((1 << HEIGHT_W) - 1);

    logic [15:0] r_peak;
    logic [15:0] w_mag;
    logic [15:0] w_peak_next;
    logic [15:0] w_shifted;

    // Two's-complement negate keeps -32768 as 0x8000 = 32768 unsigned.
    assign w_mag       = sample[15] ? (~sample + 16'd1) : sample;
    assign w_peak_next = (valid && (w_mag > r_peak)) ? w_mag : r_peak;
    assign w_shifted   = w_peak_next >> SHIFT;
    assign height      = (w_shifted > SAT) ? SAT[HEIGHT_W-1:0] : w_shifted[HEIGHT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_peak <= '0;
        end else begin
            r_peak <= w_peak_next;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bar_height_writer.sv
`default_nettype none
// ============================================================================
//  Module  : bar_height_writer
//  Brief   : Drains the sample FIFO into per-bar peak heights, writes them to
//            the bar RAM and raises data_back once per frame.
//  Revision: 1.0
// ============================================================================
module bar_height_writer #(
    parameter int NUM_BARS        = bar_viz_pkg::NUM_BARS,
    parameter int HEIGHT_W        = bar_viz_pkg::HEIGHT_W,
    parameter int ADDR_W          = 6,
    parameter int SAMPLES_PER_BAR = 256,
    parameter int SHIFT           = 9,
    parameter int GUARD_CYCLES    = 32
) (
    input  wire logic           CLOCK_50,
    input  wire logic           reset,
    bar_height_writer_if.master bus
);
    import bar_viz_pkg::*;

    localparam int BAR_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int IDX_W = BAR_W + 1;
    localparam int CNT_W = $clog2(SAMPLES_PER_BAR) + 1;
    localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    localparam logic [BAR_W-1:0] LAST_BAR = BAR_W'(NUM_BARS - 1);
    localparam logic [IDX_W-1:0] WR_END   = IDX_W'(NUM_BARS);
    localparam logic [CNT_W-1:0] WIN_LEN  = CNT_W'(SAMPLES_PER_BAR);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(SAMPLES_PER_BAR - 1);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_CYCLES - 1);

    writer_state_e       r_state;
    logic [BAR_W-1:0]    r_bar;
    logic [IDX_W-1:0]    r_wr_idx;
    logic [CNT_W-1:0]    r_req_cnt;
    logic [CNT_W-1:0]    r_rcv_cnt;
    logic [GRD_W-1:0]    r_grd_cnt;
    logic                r_sample_valid;
    logic [HEIGHT_W-1:0] r_hbuf [0:(1<<BAR_W)-1];

    logic [HEIGHT_W-1:0] w_height;
    logic                w_rdreq;
    logic                w_win_done;
    logic                w_unused_ok;

    assign w_rdreq        = (r_state == COLLECT) && !bus.fifo_rdempty && (r_req_cnt < WIN_LEN);
    assign bus.fifo_rdreq = w_rdreq;
    assign w_win_done     = r_sample_valid && (r_rcv_cnt == WIN_LAST);
    assign w_unused_ok    = &{1'b0, bus.fifo_q[15:0]};

    peak_detector #(
        .SHIFT    (SHIFT),
        .HEIGHT_W (HEIGHT_W)
    ) u_peak (
        .clk    (CLOCK_50),
        .rst    (reset),
        .valid  (r_sample_valid),
        .clear  (w_win_done),
        .sample (bus.fifo_q[31:16]),
        .height (w_height)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state           <= COLLECT;
            r_bar             <= '0;
            r_wr_idx          <= '0;
            r_req_cnt         <= '0;
            r_rcv_cnt         <= '0;
            r_grd_cnt         <= '0;
            r_sample_valid    <= 1'b0;
            bus.ram_wren      <= 1'b0;
            bus.ram_data      <= '0;
            bus.ram_wraddress <= '0;
            bus.data_back     <= 1'b0;
            for (int i = 0; i < (1 << BAR_W); i++) begin
                r_hbuf[i] <= '0;
            end
        end else begin
            r_sample_valid <= w_rdreq;
            case (r_state)
                COLLECT: begin
                    if (w_win_done) begin
                        r_hbuf[r_bar] <= w_height;
                        r_req_cnt     <= '0;
                        r_rcv_cnt     <= '0;
                        if (r_bar == LAST_BAR) begin
                            // Address 0 goes out now so the first write trails the last sample by one cycle.
                            r_state           <= WRITE;
                            r_bar             <= '0;
                            r_wr_idx          <= IDX_W'(1);
                            bus.ram_wren      <= 1'b1;
                            bus.ram_wraddress <= '0;
                            bus.ram_data      <= (r_bar == BAR_W'(0)) ? w_height : r_hbuf[BAR_W'(0)];
                        end else begin
                            r_bar <= r_bar + 1'b1;
                        end
                    end else begin
                        if (w_rdreq) begin
                            r_req_cnt <= r_req_cnt + 1'b1;
                        end
                        if (r_sample_valid) begin
                            r_rcv_cnt <= r_rcv_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (r_wr_idx == WR_END) begin
                        bus.ram_wren  <= 1'b0;
                        bus.data_back <= 1'b1;
                        r_state       <= NOTIFY;
                    end else begin
                        bus.ram_wraddress <= ADDR_W'(r_wr_idx);
                        bus.ram_data      <= r_hbuf[r_wr_idx[BAR_W-1:0]];
                        r_wr_idx          <= r_wr_idx + 1'b1;
                    end
                end
                NOTIFY: begin
                    bus.data_back <= 1'b0;
                    r_grd_cnt     <= '0;
                    r_state       <= GUARD;
                end
                GUARD: begin
                    if (r_grd_cnt == GRD_LAST) begin
                        r_state <= COLLECT;
                    end else begin
                        r_grd_cnt <= r_grd_cnt + 1'b1;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/bar_height_writer.md
Name: bar_height_writer

Overview:
- Hardware producer for the bar-height RAM and the data_back handshake.
- Drains 32-bit audio words from the dual-clock sample FIFO (read side, CLOCK_50) and computes a peak-magnitude envelope per bar over NUM_BARS consecutive sample windows.
- Writes the NUM_BARS 6-bit heights into vga_ram at addresses 0..NUM_BARS-1, then raises data_back so the frame reader latches a fresh frame.
- Replaces the Nios II software path for the FIFO-to-RAM transfer.

Parameters:
- NUM_BARS, 20, number of bars / RAM words written per frame.
- HEIGHT_W, 6, bar height and RAM data width.
- ADDR_W, 6, RAM write-address width.
- SAMPLES_PER_BAR, 256, FIFO words consumed per bar window (power of two, ≥2).
- SHIFT, 9, right shift applied to the 16-bit magnitude.
- GUARD_CYCLES, 32, idle cycles after notify; must be ≥ the reader's 24-cycle readout.

Ports:
- CLOCK_50  in  1  system clock; also the FIFO read clock and RAM clock.
- reset  in  1  synchronous, active-high.
- fifo_q  in  32  FIFO read data. Normal (non-show-ahead) mode: valid the cycle after fifo_rdreq. Bits [31:16] are the signed left sample.
- fifo_rdempty  in  1  FIFO empty.
- fifo_rdreq  out  1  FIFO read request.
- ram_data  out  HEIGHT_W  RAM write data.
- ram_wraddress  out  ADDR_W  RAM write address.
- ram_wren  out  1  RAM write enable.
- data_back  out  1  frame-ready flag; the reader acts on its rising edge.

Behaviour:
- Reset values: all outputs 0; state COLLECT; bar index, request/receive counters, peak and height buffer cleared.
- All outputs are registered except fifo_rdreq, which is a combinational function of registered state and fifo_rdempty.
- State COLLECT:
  - fifo_rdreq = !fifo_rdempty && req_cnt < SAMPLES_PER_BAR. Each asserted cycle increments req_cnt.
  - sample_valid = registered fifo_rdreq. On a valid cycle: mag = |fifo_q[31:16]| as 16-bit unsigned (-32768 → 32768); peak <= max(peak, mag); rcv_cnt++.
  - When a valid cycle brings rcv_cnt to SAMPLES_PER_BAR: hbuf[bar] <= min(peak_final >> SHIFT, 2^HEIGHT_W-1). peak_final includes the current sample. Then clear peak, req_cnt and rcv_cnt in the same cycle.
  - If bar == NUM_BARS-1, go to WRITE. Otherwise bar++.
  - FIFO empty only stalls; there is no timeout and no partial window.
- State WRITE:
  - Asserts ram_wren for exactly NUM_BARS consecutive cycles, one per address 0..NUM_BARS-1, with ram_data = hbuf[addr].
  - fifo_rdreq = 0 throughout.
  - After the last write, ram_wren <= 0 and go to NOTIFY.
- State NOTIFY: data_back <= 1 for one cycle, then go to GUARD.
- State GUARD:
  - data_back = 0; count GUARD_CYCLES cycles, then go to COLLECT with bar = 0.
  - No RAM writes occur, so the reader's readout never overlaps a write.
  - FIFO reads are also suspended; the FIFO absorbs the backlog.
- data_back therefore produces exactly one rising edge per frame, with ≥GUARD_CYCLES+NUM_BARS+SAMPLES_PER_BAR cycles between edges.
- Saturation example: peak 32768 >> 9 = 64 → clamped to 63.
- Reset mid-frame: abandons the frame with no partial writes. ram_wren and data_back drop to 0 the cycle after reset is sampled. A sample returning in flight is discarded.
- Simultaneous events: last valid sample of bar NUM_BARS-1 plus fifo_rdempty deasserting → no new request, because req_cnt is saturated at SAMPLES_PER_BAR.
- Latency: last sample of a frame → first ram_wren = 1 cycle; → data_back = NUM_BARS+1 cycles.

Decomposition:
- Package bar_viz_pkg holds:
  - typedef height_t (logic [HEIGHT_W-1:0]) and state enum writer_state_e {COLLECT, WRITE, NOTIFY, GUARD};
  - constants NUM_BARS, HEIGHT_W, MAX_HEIGHT; the existing top-level reader imports the same constants.
- One sub-module, peak_detector: abs, running max, shift and saturate. Inputs: valid, sample, clear. Output: height.

Test Plan:
- Frame content: FIFO always non-empty, bar k fed constant left sample 512*k for k=0..19 → RAM writes addr k = k in address order over 20 consecutive cycles; exactly one data_back pulse, 1 cycle after the last write.
- Negative full scale: all samples -32768 → every written height = 63 (saturation); sample +511 → height 0.
- Peak detection: window of 255 zeros then one sample -20000 as the final word → height 39 (20000>>9), proving the last sample is included.
- Stall: fifo_rdempty toggled pseudo-randomly at 50% → identical RAM contents to the non-stalled run; fifo_rdreq never asserted while empty; exactly SAMPLES_PER_BAR reads per bar.
- Handshake and guard: two back-to-back frames → no ram_wren and no fifo_rdreq within GUARD_CYCLES after data_back; data_back high for exactly 1 cycle each frame.
- Reset: reset asserted for one cycle during WRITE at address 7 → ram_wren 0 next cycle; no data_back; next frame starts at bar 0 and writes all 20 addresses.
